// File: rtl/mips_pkg.sv
// Shared core package: default bus widths and the data-memory arbiter state encoding.
package mips_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam int LW_DEF = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_DONE  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Host/debug burst port of the data-memory arbiter.
interface dmem_arbiter_if
    import mips_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
);
    logic          h_req;
    logic          h_we;
    logic [AW-1:0] h_addr;
    logic [LW-1:0] h_len;
    logic [DW-1:0] h_wdata;
    logic          h_ready;
    logic [DW-1:0] h_rdata;
    logic          h_rvalid;
    logic          h_done;
    logic          h_busy;
    logic [7:0]    h_stall;

    modport master (
        output h_req, h_we, h_addr, h_len, h_wdata,
        input  h_ready, h_rdata, h_rvalid, h_done, h_busy, h_stall
    );

    modport slave (
        input  h_req, h_we, h_addr, h_len, h_wdata,
        output h_ready, h_rdata, h_rvalid, h_done, h_busy, h_stall
    );
endinterface

// File: rtl/dmem_burst_ctr.sv
// Burst address/beat counter: loads start address and beat count, steps once per issued beat.
module dmem_burst_ctr #(
    parameter int AW = 8,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          advance,
    input  logic [AW-1:0] load_addr,
    input  logic [LW-1:0] load_len,
    output logic [AW-1:0] addr,
    output logic          last
);
    logic [AW-1:0] addr_reg;
    logic [LW-1:0] remaining_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg      <= '0;
            remaining_reg <= '0;
        end else if (load) begin
            addr_reg      <= load_addr;
            remaining_reg <= load_len;
        end else if (advance) begin
            // address wraps naturally at 2^AW
            addr_reg <= addr_reg + 1'b1;
            if (remaining_reg != '0)
                remaining_reg <= remaining_reg - 1'b1;
        end
    end

    assign addr = addr_reg;
    assign last = (remaining_reg == '0);
endmodule

// File: rtl/dmem_arbiter.sv
// Data RAM arbiter: core accesses always win, host bursts fill in the idle RAM cycles.
module dmem_arbiter
    import mips_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_breq,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    dmem_arbiter_if.slave host,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);
    arb_state_t    state_reg;
    logic          dir_reg;
    logic          owner_reg;
    logic          done_reg;
    logic          busy_reg;
    logic [7:0]    stall_reg;
    logic [AW-1:0] cur_addr;
    logic          last;
    logic          accept;
    logic          host_beat;

    // Reset gates the RAM port so an aborted burst cannot land a beat in the reset cycle.
    assign accept    = !rst && (state_reg == ARB_IDLE) && host.h_req;
    assign host_beat = !rst && (state_reg == ARB_BURST) && !c_breq;

    dmem_burst_ctr #(
        .AW(AW),
        .LW(LW)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .advance  (host_beat),
        .load_addr(host.h_addr),
        .load_len (host.h_len),
        .addr     (cur_addr),
        .last     (last)
    );

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (host_beat) begin
            m_en    = 1'b1;
            m_we    = dir_reg;
            m_addr  = cur_addr;
            m_wdata = host.h_wdata;
        end else if (!rst) begin
            m_en    = c_breq;
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ARB_IDLE;
            dir_reg   <= 1'b0;
            owner_reg <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            stall_reg <= '0;
        end else begin
            owner_reg <= host_beat && !dir_reg;
            done_reg  <= 1'b0;
            case (state_reg)
                ARB_IDLE: begin
                    if (host.h_req) begin
                        dir_reg   <= host.h_we;
                        stall_reg <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    if (c_breq) begin
                        if (stall_reg != 8'hFF)
                            stall_reg <= stall_reg + 8'd1;
                    end else if (last) begin
                        done_reg  <= 1'b1;
                        state_reg <= ARB_DONE;
                    end
                end
                ARB_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ARB_IDLE;
                end
                default: state_reg <= ARB_IDLE;
            endcase
        end
    end

    assign host.h_ready  = host_beat;
    assign host.h_rdata  = m_rdata;
    assign host.h_rvalid = owner_reg;
    assign host.h_done   = done_reg;
    assign host.h_busy   = busy_reg;
    assign host.h_stall  = stall_reg;
    assign c_rdata       = m_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a beat-queue reference model and a RAM scoreboard.
module tb_dmem_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       c_breq = 1'b0;
    logic       c_we = 1'b0;
    logic [7:0] c_addr = 8'h00;
    logic [7:0] c_wdata = 8'h00;
    logic [7:0] c_rdata;
    logic       m_en, m_we;
    logic [7:0] m_addr, m_wdata;
    logic [7:0] m_rdata = 8'h00;

    dmem_arbiter_if hif ();

    dmem_arbiter dut (
        .clk    (clk),
        .rst    (rst),
        .c_breq (c_breq),
        .c_we   (c_we),
        .c_addr (c_addr),
        .c_wdata(c_wdata),
        .c_rdata(c_rdata),
        .host   (hif),
        .m_en   (m_en),
        .m_we   (m_we),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // RAM macro: one-cycle registered read
    logic [7:0] ram [256] = '{default: 8'h00};
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) ram[m_addr] <= m_wdata;
            m_rdata <= ram[m_addr];
        end
    end

    // Reference model: memory image plus the outstanding beats of the current burst
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    logic [7:0] bdata [16];
    bit         active, done_now, dir_m;
    int         nbeats, idx, stall_m;
    logic [7:0] base_m;
    bit         pend_h, pend_c;
    logic [7:0] pend_hd, pend_cd;
    bit         dir_cwe;
    logic [7:0] dir_caddr, dir_cwd;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_cycle(input bit req, input bit we, input logic [7:0] addr, input logic [3:0] len,
                             input bit cb, input bit cwe, input logic [7:0] caddr, input logic [7:0] cwd,
                             input bit r);
        bit         idle, host_go, done_next;
        logic [7:0] a;
        rst          = r;
        hif.h_req    = req;
        hif.h_we     = we;
        hif.h_addr   = addr;
        hif.h_len    = len;
        hif.h_wdata  = active ? bdata[idx] : 8'h00;
        c_breq       = cb;
        c_we         = cwe;
        c_addr       = caddr;
        c_wdata      = cwd;
        idle         = !active && !done_now;
        host_go      = !r && active && !cb;
        a            = base_m + 8'(idx);
        @(negedge clk);
        check_eq("h_ready", 32'(hif.h_ready), 32'(host_go));
        if (host_go) begin
            check_eq("m_en_host", 32'(m_en), 32'd1);
            check_eq("m_we_host", 32'(m_we), 32'(dir_m));
            check_eq("m_addr_host", 32'(m_addr), 32'(a));
            if (dir_m) check_eq("m_wdata_host", 32'(m_wdata), 32'(bdata[idx]));
        end else if (!r && cb) begin
            check_eq("m_en_core", 32'(m_en), 32'd1);
            check_eq("m_we_core", 32'(m_we), 32'(cwe));
            check_eq("m_addr_core", 32'(m_addr), 32'(caddr));
            if (cwe) check_eq("m_wdata_core", 32'(m_wdata), 32'(cwd));
        end else begin
            check_eq("m_en_off", 32'(m_en), 32'd0);
        end
        if (!r) begin
            check_eq("h_busy", 32'(hif.h_busy), 32'(active || done_now));
            check_eq("h_done", 32'(hif.h_done), 32'(done_now));
            check_eq("h_rvalid", 32'(hif.h_rvalid), 32'(pend_h));
            check_eq("h_stall", 32'(hif.h_stall), 32'(stall_m));
            if (pend_h) check_eq("h_rdata", 32'(hif.h_rdata), 32'(pend_hd));
            if (pend_c) check_eq("c_rdata", 32'(c_rdata), 32'(pend_cd));
        end
        pend_h = 1'b0;
        pend_c = 1'b0;
        if (r) begin
            active   = 1'b0;
            done_now = 1'b0;
            stall_m  = 0;
        end else begin
            done_next = 1'b0;
            if (cb) begin
                if (cwe) ref_mem[caddr] = cwd;
                else begin
                    pend_c  = 1'b1;
                    pend_cd = ref_mem[caddr];
                end
                if (active && stall_m < 255) stall_m++;
            end else if (active) begin
                if (dir_m) ref_mem[a] = bdata[idx];
                else begin
                    pend_h  = 1'b1;
                    pend_hd = ref_mem[a];
                end
                idx++;
                if (idx == nbeats) begin
                    active    = 1'b0;
                    done_next = 1'b1;
                end
            end
            done_now = done_next;
            if (idle && req) begin
                active  = 1'b1;
                base_m  = addr;
                dir_m   = we;
                nbeats  = int'(len) + 1;
                idx     = 0;
                stall_m = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_burst(input bit we, input logic [7:0] addr, input logic [3:0] len, input bit keep_data,
                            input logic [31:0] cmask, input int force_n, input int cprob, input int rst_at);
        int         k;
        bit         cb, cwe, rq, rwe, directed;
        logic [7:0] ca, cd, ra;
        logic [3:0] rl;
        if (!keep_data)
            for (int i = 0; i < 16; i++) bdata[i] = 8'($urandom);
        k = 0;
        do begin
            directed = (k < 32) && cmask[k];
            cb  = directed || (k < force_n) || ($urandom_range(0, 99) < cprob);
            cwe = directed ? dir_cwe : 1'($urandom);
            ca  = directed ? dir_caddr : 8'($urandom);
            cd  = directed ? dir_cwd : 8'($urandom);
            if (k == 0) begin
                rq = 1'b1; rwe = we; ra = addr; rl = len;
            end else begin
                rq = 1'($urandom); rwe = 1'($urandom); ra = 8'($urandom); rl = 4'($urandom);
            end
            run_cycle(rq, rwe, ra, rl, cb, cwe, ca, cd, k == rst_at);
            k++;
        end while ((active || done_now) && k < 2000);
        $display("burst we=%0b addr=%02h beats=%0d cycles=%0d stalls=%0d%s",
                 we, addr, int'(len) + 1, k, stall_m, (rst_at >= 0 && rst_at < k) ? " (reset)" : "");
    endtask

    task automatic idle_cycles(input int n, input int cprob);
        for (int i = 0; i < n; i++)
            run_cycle(1'b0, 1'b0, 8'h00, 4'h0, $urandom_range(0, 99) < cprob, 1'($urandom),
                      8'($urandom), 8'($urandom), 1'b0);
    endtask

    initial begin
        hif.h_req   = 1'b0;
        hif.h_we    = 1'b0;
        hif.h_addr  = 8'h00;
        hif.h_len   = 4'h0;
        hif.h_wdata = 8'h00;
        #1;
        run_cycle(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        run_cycle(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        idle_cycles(1, 0);

        // plain write burst of A0..A3 at 0x10
        for (int i = 0; i < 16; i++) bdata[i] = 8'hA0 + 8'(i);
        do_burst(1'b1, 8'h10, 4'd3, 1'b1, 32'h0, 0, 0, -1);
        for (int i = 0; i < 4; i++) check_eq("wr_ram", 32'(ram[8'h10 + 8'(i)]), 32'hA0 + 32'(i));
        check_eq("wr_stall_zero", 32'(hif.h_stall), 32'd0);

        do_burst(1'b0, 8'h10, 4'd3, 1'b1, 32'h0, 0, 0, -1);

        // address wrap through 0xFF
        do_burst(1'b1, 8'hFE, 4'd2, 1'b0, 32'h0, 0, 0, -1);
        check_eq("wrap_fe", 32'(ram[8'hFE]), 32'(bdata[0]));
        check_eq("wrap_ff", 32'(ram[8'hFF]), 32'(bdata[1]));
        check_eq("wrap_00", 32'(ram[8'h00]), 32'(bdata[2]));

        // core store collides with host beat 2
        dir_cwe = 1'b1; dir_caddr = 8'h20; dir_cwd = 8'h55;
        do_burst(1'b1, 8'h40, 4'd3, 1'b0, 32'h4, 0, 0, -1);
        check_eq("core_store", 32'(ram[8'h20]), 32'h55);
        check_eq("stall_one", 32'(hif.h_stall), 32'd1);

        // core load of 0x11 inside a host read burst
        dir_cwe = 1'b0; dir_caddr = 8'h11; dir_cwd = 8'h00;
        do_burst(1'b0, 8'h10, 4'd3, 1'b1, 32'h4, 0, 0, -1);

        // reset after the first beat
        do_burst(1'b1, 8'h80, 4'd3, 1'b0, 32'h0, 0, 0, 2);
        check_eq("rst_beat0", 32'(ram[8'h80]), 32'(bdata[0]));
        check_eq("rst_beat1", 32'(ram[8'h81]), 32'h00);
        check_eq("rst_busy", 32'(hif.h_busy), 32'd0);
        do_burst(1'b1, 8'h84, 4'd1, 1'b0, 32'h0, 0, 0, -1);

        // stall counter saturation
        do_burst(1'b1, 8'h30, 4'd0, 1'b0, 32'h0, 300, 0, -1);
        check_eq("stall_sat", 32'(hif.h_stall), 32'd255);

        for (int b = 0; b < 40; b++) begin
            do_burst(1'($urandom), 8'($urandom), 4'($urandom), 1'b0, 32'h0, 0, $urandom_range(0, 60),
                     ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1);
            idle_cycles($urandom_range(0, 3), 40);
        end

        idle_cycles(2, 0);
        for (int i = 0; i < 256; i++) check_eq("mem_image", 32'(ram[i]), 32'(ref_mem[i]));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
